idct_building_block: RTL and testbench
======================================

Name: idct_building_block

Overview:
- Inverse butterfly stage for the DCT datapath. It undoes one forward butterfly stage: from a transformed (top, bottom) pair of m-lane vectors it recovers the original pair.
- It is a 2-stage pipeline with valid/ready handshakes on input and output, so stages can be chained with backpressure.
- It sits on the IDCT side of the codec, mirroring the forward stage placement.

Parameters:
- m, 1, lanes per vector; each lane is 18-bit signed.
- COEFF_INV, 256, signed Q8 reciprocal of the forward coefficient (65536/COEFF); 256 means 1.0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  input pair valid.
- in_ready  out  1  stage can accept an input this cycle.
- top_in_flat  in  m*18  transformed top vector; lane k is bits [k*18 +: 18].
- bot_in_flat  in  m*18  transformed bottom vector; same packing.
- out_valid  out  1  recovered pair valid.
- out_ready  in  1  downstream accepts the output.
- top_out_flat  out  m*18  recovered top vector.
- bot_out_flat  out  m*18  recovered bottom vector.

Behaviour:
- Reset (reset_n low, asynchronous): both stage-valid flags, out_valid, top_out_flat and bot_out_flat clear to 0. in_ready reads 1 once reset is released.
- Reset mid-operation: in-flight data is discarded with no partial output.
- Transfer rule: a transfer occurs when valid && ready on the same edge.
- Stage advance: each stage loads when its own slot is empty, or when its contents move forward in the same cycle.
- in_ready = !s1_valid || s1_adv.
- s1_adv = !s2_valid || out_ready.
- Throughput and latency: one pair per cycle at full rate; an input accepted at edge N gives out_valid at edge N+2.
- Stall: while out_valid && !out_ready, the outputs hold stable. Valid is never dropped and data never changes under a stall.
- Stage 1, per lane i:
  - T = top_in[i], B = bot_in[i].
  - sum_h = (T+B) >>> 1, computed at 19 bits, arithmetic shift, result 18 bits.
  - diff_h = (T-B) >>> 1, same width rules.
  - Register both.
- Stage 2, per lane i:
  - prod = diff_h * COEFF_INV (36-bit signed).
  - p = prod[25:8], arithmetic >>>8 truncated to 18 bits.
  - top_out[i] = sum_h + p, wrap to 18 bits.
  - bot_out[m-1-i] = p. The lane reversal undoes the forward stage's reversed bottom indexing.
- Round trip: with COEFF_INV=256, the stage exactly inverts a forward stage with COEFF=256 whenever no overflow occurred in the forward stage.
- Simultaneous accept and emit in the same cycle is legal and sustains full rate.

Optional Feature:
- Macro IDCT_SAT_EN.
- Defined: p saturates to [-131072, 131071] instead of truncating, and top_out saturates likewise. No other timing change.
- Undefined: two's-complement wrap as above.

Decomposition:
- Shared package (dct_pkg) holds:
  - LANE_W=18, COEFF_FRAC=8, lane typedef signed [17:0].
  - sat18 constant limits and a saturate function, used only under IDCT_SAT_EN.
- One natural sub-module, idct_lane: the per-lane stage-1/stage-2 arithmetic, generated m times.
- Handshake control stays in the top module and is shared by all lanes.

Test Plan:
- Round trip, m=1, COEFF_INV=256, forward inputs t=1000, b=300:
  - Drive T=1000, B=400.
  - Expect top_out=1000, bot_out=300, two cycles after acceptance.
- Lane reversal, m=2: top_in={T1=50,T0=10}, B0=-10, B1=30 (bot_in packed {B1,B0}):
  - Lane 0: sum_h=0, diff_h=10, p=10, so top_out lane0 = 10 and bot_out lane1 = 10.
  - Lane 1: sum_h=40, diff_h=10, p=10, so top_out lane1 = 50 and bot_out lane0 = 10.
- Backpressure: stream 5 pairs with out_ready held low for cycles 3-6.
  - in_ready drops after both stages fill.
  - Outputs are held constant through the stall.
  - All 5 results emerge in order, none lost or duplicated.
- Full rate: out_ready tied 1, in_valid tied 1 for 16 cycles.
  - 16 outputs on 16 consecutive cycles after a 2-cycle fill.
- Reset mid-stream: assert reset_n low asynchronously between edges while both stages are valid.
  - out_valid and outputs go to 0 immediately.
  - No stale output after release.
- Overflow, COEFF_INV=512, T=131071, B=-131071:
  - Without IDCT_SAT_EN: top_out = -2, bot_out = -2.
  - With IDCT_SAT_EN: top_out = 131071, bot_out = 131071.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared DCT datapath definitions: lane format, coefficient fraction bits and an
// 18-bit saturation helper (only referenced when IDCT_SAT_EN is defined).
package dct_pkg;

  localparam int LANE_W     = 18;
  localparam int COEFF_FRAC = 8;

  typedef logic signed [LANE_W-1:0] lane_t;

  localparam lane_t SAT18_MAX = 18'sh1FFFF;
  localparam lane_t SAT18_MIN = 18'sh20000;

  function automatic lane_t sat18(input logic signed [35:0] v);
    lane_t r;
    if (v > 36'sd131071) begin
      r = SAT18_MAX;
    end else if (v < -36'sd131072) begin
      r = SAT18_MIN;
    end else begin
      r = lane_t'(v[LANE_W-1:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/idct_lane.sv
// One lane of the inverse butterfly: stage 1 forms halved sum/difference, stage 2
// rescales the difference by COEFF_INV (Q8). IDCT_SAT_EN saturates instead of wrapping.
module idct_lane
  import dct_pkg::*;
#(
  parameter int COEFF_INV = 256
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  i_ld1,
  input  logic  i_ld2,
  input  lane_t i_top,
  input  lane_t i_bot,
  output lane_t o_top,
  output lane_t o_p
);

  localparam logic signed [35:0] COEFF_EXT = 36'(COEFF_INV);

  logic signed [LANE_W:0] w_sum;
  logic signed [LANE_W:0] w_diff;
  logic signed [35:0]     w_prod;
  lane_t                  w_p;
  lane_t                  w_top;
  logic                   w_unused_lsb;

  lane_t r_sum_h;
  lane_t r_diff_h;
  lane_t r_top;
  lane_t r_p;

  // Widen by one bit so the sum/difference never overflows before the halving shift.
  assign w_sum        = {i_top[LANE_W-1], i_top} + {i_bot[LANE_W-1], i_bot};
  assign w_diff       = {i_top[LANE_W-1], i_top} - {i_bot[LANE_W-1], i_bot};
  assign w_unused_lsb = w_sum[0] ^ w_diff[0];

  assign w_prod = {{(36-LANE_W){r_diff_h[LANE_W-1]}}, r_diff_h} * COEFF_EXT;

`ifdef IDCT_SAT_EN
  logic signed [LANE_W:0] w_top_wide;

  assign w_p        = sat18(w_prod >>> COEFF_FRAC);
  assign w_top_wide = {r_sum_h[LANE_W-1], r_sum_h} + {w_p[LANE_W-1], w_p};
  assign w_top      = sat18(36'(w_top_wide));
`else
  logic w_unused_prod;

  assign w_p           = w_prod[COEFF_FRAC +: LANE_W];
  assign w_top         = r_sum_h + w_p;
  assign w_unused_prod = ^{w_prod[35:COEFF_FRAC+LANE_W], w_prod[COEFF_FRAC-1:0]};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum_h  <= '0;
      r_diff_h <= '0;
      r_top    <= '0;
      r_p      <= '0;
    end else begin
      if (i_ld1) begin
        r_sum_h  <= w_sum[LANE_W:1];
        r_diff_h <= w_diff[LANE_W:1];
      end
      if (i_ld2) begin
        r_top <= w_top;
        r_p   <= w_p;
      end
    end
  end

  assign o_top = r_top;
  assign o_p   = r_p;

endmodule

// File: rtl/idct_building_block.sv
// Two-stage inverse butterfly with valid/ready on both sides; m lanes share one
// handshake controller. Build with IDCT_SAT_EN to saturate instead of wrap.
module idct_building_block
  import dct_pkg::*;
#(
  parameter int m         = 1,
  parameter int COEFF_INV = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [m*LANE_W-1:0]   top_in_flat,
  input  logic [m*LANE_W-1:0]   bot_in_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [m*LANE_W-1:0]   top_out_flat,
  output logic [m*LANE_W-1:0]   bot_out_flat
);

  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s1_adv;
  logic w_ld1;
  logic w_ld2;

  // A stage may load when it is empty or its contents leave in the same cycle.
  assign w_s1_adv  = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign w_ld1     = in_valid && in_ready;
  assign w_ld2     = r_s1_valid && w_s1_adv;
  assign out_valid = r_s2_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < m; gi++) begin : g_lane
      lane_t w_top_out;
      lane_t w_p;

      idct_lane #(
        .COEFF_INV(COEFF_INV)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .i_ld1   (w_ld1),
        .i_ld2   (w_ld2),
        .i_top   (top_in_flat[gi*LANE_W +: LANE_W]),
        .i_bot   (bot_in_flat[gi*LANE_W +: LANE_W]),
        .o_top   (w_top_out),
        .o_p     (w_p)
      );

      // Bottom lanes come out reversed to undo the forward stage's reversed indexing.
      assign top_out_flat[gi*LANE_W +: LANE_W]        = w_top_out;
      assign bot_out_flat[(m-1-gi)*LANE_W +: LANE_W]  = w_p;
    end
  endgenerate

endmodule

// File: tb/tb_idct_building_block.sv
// Directed bench: m=2/COEFF_INV=256 instance for function and handshake,
// m=1/COEFF_INV=512 instance for overflow; expectations track IDCT_SAT_EN.
module tb_idct_building_block;

  typedef struct {
    int t0; int t1; int b0; int b1;
    int et0; int et1; int eb0; int eb1;
  } vec_t;

  logic        clk;
  logic        reset_n;

  logic        in_valid;
  logic        in_ready;
  logic [35:0] top_in;
  logic [35:0] bot_in;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] top_out;
  logic [35:0] bot_out;

  logic        ov_in_valid;
  logic        ov_in_ready;
  logic [17:0] ov_top_in;
  logic [17:0] ov_bot_in;
  logic        ov_out_valid;
  logic        ov_out_ready;
  logic [17:0] ov_top_out;
  logic [17:0] ov_bot_out;

  int checks = 0;
  int errors = 0;

  vec_t vecs[5];
  vec_t stream_q[$];

  idct_building_block #(.m(2), .COEFF_INV(256)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .top_in_flat  (top_in),
    .bot_in_flat  (bot_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .top_out_flat (top_out),
    .bot_out_flat (bot_out)
  );

  idct_building_block #(.m(1), .COEFF_INV(512)) u_ovf (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (ov_in_valid),
    .in_ready     (ov_in_ready),
    .top_in_flat  (ov_top_in),
    .bot_in_flat  (ov_bot_in),
    .out_valid    (ov_out_valid),
    .out_ready    (ov_out_ready),
    .top_out_flat (ov_top_out),
    .bot_out_flat (ov_bot_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [35:0] pk2(input int hi, input int lo);
    logic [31:0] h;
    logic [31:0] l;
    h = hi;
    l = lo;
    return {h[17:0], l[17:0]};
  endfunction

  function automatic logic [17:0] pk1(input int v);
    logic [31:0] x;
    x = v;
    return x[17:0];
  endfunction

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Single isolated transaction on the m=2 instance, checking exact 2-edge latency.
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    top_in    = pk2(v.t1, v.t0);
    bot_in    = pk2(v.b1, v.b0);
    #1;
    chk($sformatf("vec%0d_in_ready", idx), 36'(in_ready), 36'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("vec%0d_early_valid", idx), 36'(out_valid), 36'd0);
    @(negedge clk);
    chk($sformatf("vec%0d_out_valid", idx), 36'(out_valid), 36'd1);
    chk($sformatf("vec%0d_top", idx), top_out, pk2(v.et1, v.et0));
    chk($sformatf("vec%0d_bot", idx), bot_out, pk2(v.eb1, v.eb0));
    $display("vec%0d top_in=%h bot_in=%h -> top_out=%h bot_out=%h",
             idx, pk2(v.t1, v.t0), pk2(v.b1, v.b0), top_out, bot_out);
  endtask

  task automatic ovf_one(input int t, input int b, input int et, input int eb, input string name);
    @(negedge clk);
    ov_in_valid  = 1'b1;
    ov_out_ready = 1'b1;
    ov_top_in    = pk1(t);
    ov_bot_in    = pk1(b);
    @(negedge clk);
    ov_in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 36'(ov_out_valid), 36'd1);
    chk({name, "_top"}, 36'(ov_top_out), 36'(pk1(et)));
    chk({name, "_bot"}, 36'(ov_bot_out), 36'(pk1(eb)));
    $display("%s T=%0d B=%0d -> top_out=%h bot_out=%h", name, t, b, ov_top_out, ov_bot_out);
  endtask

  // Streams stream_q with in_valid held whenever data remains; out_ready low in [stall_lo, stall_hi].
  task automatic run_stream(input string name, input int stall_lo, input int stall_hi,
                            output int first_emit, output int last_emit, output bit saw_low);
    int          n;
    int          sent;
    int          got;
    bit          prev_stall;
    logic [35:0] held_top;
    logic [35:0] held_bot;
    n          = stream_q.size();
    sent       = 0;
    got        = 0;
    prev_stall = 1'b0;
    held_top   = '0;
    held_bot   = '0;
    first_emit = -1;
    last_emit  = -1;
    saw_low    = 1'b0;
    for (int c = 0; c < 80 && got < n; c++) begin
      @(negedge clk);
      out_ready = !(c >= stall_lo && c <= stall_hi);
      if (sent < n) begin
        in_valid = 1'b1;
        top_in   = pk2(stream_q[sent].t1, stream_q[sent].t0);
        bot_in   = pk2(stream_q[sent].b1, stream_q[sent].b0);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        chk({name, "_hold_valid"}, 36'(out_valid), 36'd1);
        chk({name, "_hold_top"}, top_out, held_top);
        chk({name, "_hold_bot"}, bot_out, held_bot);
      end
      if (!in_ready) saw_low = 1'b1;
      if (out_valid && out_ready) begin
        chk({name, "_top"}, top_out, pk2(stream_q[got].et1, stream_q[got].et0));
        chk({name, "_bot"}, bot_out, pk2(stream_q[got].eb1, stream_q[got].eb0));
        $display("%s cycle=%0d out%0d top_out=%h bot_out=%h", name, c, got, top_out, bot_out);
        if (first_emit < 0) first_emit = c;
        last_emit = c;
        got++;
      end
      prev_stall = out_valid && !out_ready;
      held_top   = top_out;
      held_bot   = bot_out;
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({name, "_count"}, 36'(got), 36'(n));
  endtask

  initial begin
    int  first_emit;
    int  last_emit;
    bit  saw_low;
    int  wrap_top;

`ifdef IDCT_SAT_EN
    wrap_top = -131072;
`else
    wrap_top = 131071;
`endif
    vecs[0] = '{1000, 50, 400, 30, 1000, 50, 10, 300};
    vecs[1] = '{10, 50, -10, 30, 10, 50, 10, 10};
    vecs[2] = '{7, -7, 2, 2, 6, -8, -5, 2};
    vecs[3] = '{131071, -131072, 131071, -131072, 131071, -131072, 0, 0};
    vecs[4] = '{-131072, 0, 131071, 0, wrap_top, 0, 0, -131072};

    reset_n      = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    top_in       = '0;
    bot_in       = '0;
    ov_in_valid  = 1'b0;
    ov_out_ready = 1'b1;
    ov_top_in    = '0;
    ov_bot_in    = '0;

    #2;
    chk("reset_out_valid", 36'(out_valid), 36'd0);
    chk("reset_top_out", top_out, 36'd0);
    chk("reset_bot_out", bot_out, 36'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_in_ready", 36'(in_ready), 36'd1);
    $display("reset released out_valid=%0b in_ready=%0b", out_valid, in_ready);

    for (int i = 0; i < 5; i++) begin
      apply_vec(vecs[i], i);
    end

    // Backpressure: five pairs, out_ready low for cycles 3..6.
    stream_q.delete();
    for (int i = 0; i < 5; i++) stream_q.push_back(vecs[i]);
    run_stream("bp", 3, 6, first_emit, last_emit, saw_low);
    chk("bp_in_ready_dropped", 36'(saw_low), 36'd1);

    // Full rate: 16 pairs back to back, no stall.
    @(negedge clk);
    stream_q.delete();
    for (int k = 1; k <= 16; k++) begin
      stream_q.push_back('{2*k, 4*k, 0, 2*k, 2*k, 4*k, k, k});
    end
    run_stream("fr", 1000, 1000, first_emit, last_emit, saw_low);
    chk("fr_first_cycle", 36'(first_emit), 36'd2);
    chk("fr_consecutive", 36'(last_emit - first_emit), 36'd15);
    chk("fr_never_stalled", 36'(saw_low), 36'd0);

    // Reset mid-stream with both stages occupied.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    top_in    = pk2(vecs[0].t1, vecs[0].t0);
    bot_in    = pk2(vecs[0].b1, vecs[0].b0);
    @(negedge clk);
    top_in    = pk2(vecs[2].t1, vecs[2].t0);
    bot_in    = pk2(vecs[2].b1, vecs[2].b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rst_pre_valid", 36'(out_valid), 36'd1);
    chk("rst_pre_in_ready", 36'(in_ready), 36'd0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 36'(out_valid), 36'd0);
    chk("rst_top_out", top_out, 36'd0);
    chk("rst_bot_out", bot_out, 36'd0);
    $display("mid-stream reset out_valid=%0b top_out=%h bot_out=%h", out_valid, top_out, bot_out);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rst_no_stale_%0d", c), 36'(out_valid), 36'd0);
    end

    // COEFF_INV=512 instance: plain scaling, then the overflow corner.
    ovf_one(1000, 400, 1300, 600, "ovf_scale");
`ifdef IDCT_SAT_EN
    ovf_one(131071, -131071, 131071, 131071, "ovf_edge");
`else
    ovf_one(131071, -131071, -2, -2, "ovf_edge");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
